// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            stable;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // a release is accepted the same way but never pulses
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Turns the divided tick into a single-cycle core enable with run/step/pause/halt control.
// state | meaning: PAUSE no enables | RUN one enable per tick | STEP one enable then PAUSE | HALT core halted
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 32
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_in,
  output logic             cpu_ce,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] ce_count
);

  logic   tick_s1, tick_s2, tick_s3, tick_rise;
  logic   run_s1, run_s2;
  logic   step_req;
  state_e state;

  // tick_rise is registered so it lands 3 cycles after tick_in rises
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_s3   <= 1'b0;
      tick_rise <= 1'b0;
      run_s1    <= 1'b0;
      run_s2    <= 1'b0;
    end else begin
      tick_s1   <= tick_in;
      tick_s2   <= tick_s1;
      tick_s3   <= tick_s2;
      tick_rise <= tick_s2 & ~tick_s3;
      run_s1    <= run_sw;
      run_s2    <= run_s1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .btn     (step_btn),
    .press   (step_req)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PAUSE;
      cpu_ce   <= 1'b0;
      ce_count <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (halt_in) begin
        state <= HALT;
      end else begin
        case (state)
          PAUSE: begin
            if (run_s2)        state <= RUN;
            else if (step_req) state <= STEP;
          end
          RUN: begin
            if (tick_rise) begin
              cpu_ce   <= 1'b1;
              ce_count <= ce_count + 1'b1;
            end
            if (!run_s2) state <= PAUSE;
          end
          STEP: begin
            if (tick_rise) begin
              cpu_ce   <= 1'b1;
              ce_count <= ce_count + 1'b1;
              state    <= PAUSE;
            end
          end
          HALT:    state <= PAUSE;
          default: state <= PAUSE;
        endcase
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: DEBOUNCE_CYCLES=4, tick period 10 clock_in cycles.
module tb_cpu_clk_ctrl;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        tick_in  = 1'b0;
  logic        run_sw   = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_in  = 1'b0;
  logic        cpu_ce;
  logic [1:0]  state_out;
  logic [31:0] ce_count;
  logic        cpu_ce_w;
  logic [1:0]  state_w;
  logic [3:0]  ce_count_w;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int rise_cyc = -100;
  int tph = 9;
  bit tick_en = 1'b0;
  int pulses = 0;
  int step_entries = 0;
  logic       prev_ce = 1'b0;
  logic [1:0] prev_st = 2'd0;

  always #5 clock_in = ~clock_in;

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(32)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .tick_in  (tick_in),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_in  (halt_in),
    .cpu_ce   (cpu_ce),
    .state_out(state_out),
    .ce_count (ce_count)
  );

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_w (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .tick_in  (tick_in),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_in  (halt_in),
    .cpu_ce   (cpu_ce_w),
    .state_out(state_w),
    .ce_count (ce_count_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample post-edge outputs, then advance the tick_in waveform.
  task automatic cyc1();
    logic nt;
    @(posedge clock_in);
    #1;
    cyc++;
    if (cpu_ce) begin
      pulses++;
      chk("ce_lat", 32'(cyc - rise_cyc), 32'd4);
      chk("ce_width", {31'b0, prev_ce}, 32'd0);
    end
    prev_ce = cpu_ce;
    if (state_out == 2'd2 && prev_st != 2'd2) step_entries++;
    prev_st = state_out;
    if (tick_en) begin
      tph = (tph + 1) % 10;
      nt = (tph < 5);
      if (nt && !tick_in) rise_cyc = cyc;
      tick_in = nt;
    end else begin
      tick_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_in  = 1'b0;
    tick_en  = 1'b0;
    tick_in  = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    reset_n      = 1'b1;
    prev_ce      = 1'b0;
    prev_st      = 2'd0;
    pulses       = 0;
    step_entries = 0;
  endtask

  initial begin
    // free run
    do_reset();
    chk("rst_ce", {31'b0, cpu_ce}, 32'd0);
    chk("rst_state", {30'b0, state_out}, 32'd0);
    chk("rst_count", ce_count, 32'd0);
    run_sw = 1'b1; tph = 9; tick_en = 1'b1;
    repeat (100) cyc1();
    chk("run_pulses", 32'(pulses), 32'd10);
    chk("run_count", ce_count, 32'd10);
    chk("run_count_w", {28'b0, ce_count_w}, 32'd10);
    chk("run_state", {30'b0, state_out}, 32'd1);

    // bouncing step press
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_btn = (i % 2 == 0);
      cyc1();
    end
    step_btn = 1'b1;
    repeat (10) cyc1();
    chk("step_wait_state", {30'b0, state_out}, 32'd2);
    step_btn = 1'b0;
    repeat (10) cyc1();
    chk("step_hold_ce", 32'(pulses), 32'd0);
    tph = 9; tick_en = 1'b1;
    repeat (20) cyc1();
    chk("step_pulses", 32'(pulses), 32'd1);
    chk("step_entries", 32'(step_entries), 32'd1);
    chk("step_state", {30'b0, state_out}, 32'd0);
    chk("step_count", ce_count, 32'd1);

    // second press while waiting in STEP is dropped
    do_reset();
    step_btn = 1'b1; repeat (10) cyc1();
    step_btn = 1'b0; repeat (10) cyc1();
    step_btn = 1'b1; repeat (10) cyc1();
    step_btn = 1'b0; repeat (10) cyc1();
    chk("dbl_wait_state", {30'b0, state_out}, 32'd2);
    tph = 9; tick_en = 1'b1;
    repeat (25) cyc1();
    chk("dbl_pulses", 32'(pulses), 32'd1);
    chk("dbl_state", {30'b0, state_out}, 32'd0);
    chk("dbl_count", ce_count, 32'd1);

    // halt arriving with tick_rise
    do_reset();
    run_sw = 1'b1; tph = 9; tick_en = 1'b1;
    repeat (4) cyc1();
    halt_in = 1'b1;
    cyc1();
    chk("halt_ce", {31'b0, cpu_ce}, 32'd0);
    chk("halt_state", {30'b0, state_out}, 32'd3);
    pulses = 0;
    repeat (50) cyc1();
    chk("halt_hold_pulses", 32'(pulses), 32'd0);
    chk("halt_hold_state", {30'b0, state_out}, 32'd3);
    halt_in = 1'b0;
    cyc1();
    chk("unhalt_pause", {30'b0, state_out}, 32'd0);
    cyc1();
    chk("unhalt_run", {30'b0, state_out}, 32'd1);
    pulses = 0;
    repeat (20) cyc1();
    chk("resume_pulses", 32'(pulses), 32'd2);

    // run_sw drops together with tick_rise
    do_reset();
    run_sw = 1'b1;
    repeat (5) cyc1();
    chk("drop_pre_state", {30'b0, state_out}, 32'd1);
    tph = 9; tick_en = 1'b1;
    repeat (2) cyc1();
    run_sw = 1'b0;
    repeat (3) cyc1();
    chk("drop_ce", {31'b0, cpu_ce}, 32'd1);
    chk("drop_state", {30'b0, state_out}, 32'd0);
    repeat (20) cyc1();
    chk("drop_pulses", 32'(pulses), 32'd1);
    chk("drop_count", ce_count, 32'd1);

    // 4-bit counter wrap, then async reset mid-pulse
    do_reset();
    run_sw = 1'b1; tph = 9; tick_en = 1'b1;
    repeat (160) cyc1();
    chk("wrap_pulses", 32'(pulses), 32'd16);
    chk("wrap_count_w", {28'b0, ce_count_w}, 32'd0);
    chk("wrap_count", ce_count, 32'd16);
    for (int i = 0; i < 20; i++) begin
      if (cpu_ce) break;
      cyc1();
    end
    chk("pre_rst_ce", {31'b0, cpu_ce}, 32'd1);
    chk("pre_rst_count", ce_count, 32'd17);
    reset_n = 1'b0;
    #1;
    chk("arst_ce", {31'b0, cpu_ce}, 32'd0);
    chk("arst_ce_w", {31'b0, cpu_ce_w}, 32'd0);
    chk("arst_count", ce_count, 32'd0);
    chk("arst_count_w", {28'b0, ce_count_w}, 32'd0);
    chk("arst_state", {30'b0, state_out}, 32'd0);
    chk("arst_state_w", {30'b0, state_w}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Sits directly downstream of the Clock_divider.
- Consumes its slow divided clock (tick_in) in the fast FPGA clock domain and produces a single-cycle clock enable (cpu_ce) for the Y86 core.
- Provides run, single-step, pause and halt control from a board switch, a push-button and the core's halt status.
- Keeps the core on one clock; no gated or derived clocks reach the datapath.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-input cycles of clock_in needed to accept a step_btn level change (10 ms at 100 MHz).
- CNT_W, 32, width of ce_count.

Ports:
- clock_in  input  1  FPGA system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided clock from Clock_divider; treated as asynchronous.
- run_sw  input  1  board switch; high = free-run.
- step_btn  input  1  push-button, raw and bouncing; press = high.
- halt_in  input  1  core halt status; high = core halted.
- cpu_ce  output  1  one-clock_in-cycle enable for the core.
- state_out  output  2  FSM state: 0 PAUSE, 1 RUN, 2 STEP, 3 HALT.
- ce_count  output  CNT_W  count of cpu_ce pulses issued.

Behaviour:
- Reset: asynchronous assert on reset_n low. All flops clear: cpu_ce=0, state_out=0 (PAUSE), ce_count=0, synchronizers=0, debounce counter=0, stable button=0.
- Synchronizers:
  - tick_in, run_sw and step_btn each pass through a 2-flop synchronizer.
  - halt_in is already synchronous and is used directly.
- Tick edge:
  - tick_rise = synced tick high AND previous synced tick low.
  - tick_rise is a 1-cycle pulse, 3 clock_in cycles after tick_in rises.
- Debounce:
  - While synced button != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - Counter clears whenever synced == stable.
  - step_req = 1-cycle pulse on stable rising edge. Release is debounced identically but produces no pulse.
- FSM, next-state priority (halt_in highest in every state):
  - Any state, halt_in=1 -> HALT.
  - PAUSE: run_sw=1 -> RUN; else step_req -> STEP; else stay.
  - RUN: tick_rise -> cpu_ce next cycle. run_sw=0 -> PAUSE.
  - STEP: wait for tick_rise; then cpu_ce next cycle and -> PAUSE. Additional step_req in STEP is dropped, not queued.
  - HALT: cpu_ce never asserted. halt_in=0 -> PAUSE, even if run_sw=1; RUN is entered the following cycle.
- cpu_ce timing:
  - cpu_ce is registered: asserted the cycle after tick_rise when the current state is RUN or STEP and halt_in=0.
  - Exactly one cycle wide.
  - At most one pulse per tick_in period.
- Simultaneous events:
  - tick_rise with run_sw falling in RUN: the pulse is issued, then PAUSE.
  - tick_rise with halt_in=1: no pulse; -> HALT.
  - step_req with run_sw=1 in PAUSE: RUN wins; the step is dropped.
- ce_count: increments in the same cycle cpu_ce is high; wraps modulo 2^CNT_W with no saturation.
- Reset mid-pulse: cpu_ce drops immediately (asynchronous clear). No pulse is issued for a tick_rise in flight.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - state encoding constants: PAUSE=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3;
  - the default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce: 2-flop sync, debounce counter, stable level and rising-edge pulse output; parameter DEBOUNCE_CYCLES.
- Synchronizers for tick_in and run_sw are inline flops in the top.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4 and tick_in period 10 clock_in cycles.
- Reset, then run_sw=1 for 100 cycles -> exactly 10 cpu_ce pulses, each 1 cycle wide, each 4 cycles after a tick_in rise; ce_count=10.
- run_sw=0, step_btn bounce 1-0-1-0-1 at 1-cycle intervals, then held high 10 cycles -> exactly 1 step_req and exactly 1 cpu_ce on the next tick; state returns to 0; ce_count=1.
- Second step press while state=2 (waiting for tick) -> still only 1 cpu_ce; state 2->0.
- RUN, halt_in=1 in the same cycle as tick_rise -> no cpu_ce, state_out=3. Hold 50 cycles -> no cpu_ce. halt_in=0 with run_sw=1 -> state 0 then 1; pulses resume.
- RUN, run_sw drops in the same cycle as tick_rise -> one final cpu_ce, then state_out=0.
- Preload via CNT_W=4: 16 pulses -> ce_count wraps to 0. reset_n low mid-run while cpu_ce=1 -> cpu_ce, ce_count and state_out are 0 immediately, without waiting for a clock edge.
